wb_rr_arbiter4: RTL and testbench
=================================

Name: wb_rr_arbiter4

Overview:
Four-master, one-slave Wishbone arbiter with round-robin fairness, per-cycle bus lock and a stalled-slave watchdog. It sits in front of the clock-domain resync FIFO (or any single WB slave) and lets up to four masters share that slave. The granted master owns the bus for its whole cyc_i assertion, which makes back-to-back strobes atomic. A slave that never acks is broken out with an error pulse rather than hanging the bus.

Parameters:
TIMEOUT_W, 8, width of the watchdog counter.
TIMEOUT, 255, cycles with owner stb high and no ack before err is issued; valid range 1..2^TIMEOUT_W-1.

Ports:
wb_clk_i  in  1  single clock for all logic
wb_rst_i  in  1  reset; synchronous, active-high
wbN_cyc_i  in  1  master N cycle request (N=1..4, applies to every wbN_ line)
wbN_stb_i  in  1  master N strobe
wbN_we_i  in  1  master N write enable
wbN_sel_i  in  4  master N byte selects
wbN_adr_i  in  32  master N address
wbN_dat_i  in  32  master N write data
wbN_dat_o  out  32  read data; wbowner_dat_i broadcast to all masters
wbN_ack_o  out  1  ack, routed to the granted master only
wbN_err_o  out  1  watchdog error pulse, granted master only
wbowner_cyc_o  out  1  slave-side cycle
wbowner_stb_o  out  1  slave-side strobe
wbowner_we_o  out  1  muxed we
wbowner_sel_o  out  4  muxed sel
wbowner_adr_o  out  32  muxed address
wbowner_dat_o  out  32  muxed write data
wbowner_dat_i  in  32  slave read data
wbowner_ack_i  in  1  slave ack
grant_o  out  4  one-hot current owner (bit0 = master 1), 0 when idle

Behaviour:
- Reset: state=IDLE, grant_o=0, last-grant pointer=4 (master 1 has highest priority first), watchdog=0. All ack_o/err_o=0, wbowner_cyc_o/stb_o=0.
- IDLE: if any wbN_cyc_i=1, grant the first requester scanning upward from last+1 with wrap (4->1). grant_o and the pointer register at the clock edge, then state=GRANT.
- Grant latency: 1 cycle from cyc_i sampled to wbowner_cyc_o.
- IDLE with no request: stay in IDLE.
- GRANT: wbowner_cyc_o/we/sel/adr/dat are combinationally muxed from the granted master. wbowner_stb_o = granted stb_i & !timeout_fire.
  - Non-granted masters see ack_o=0 and err_o=0 and simply wait. No retry/abort signalling.
  - Multiple stb_i under one cyc_i stay with the same owner (lock).
- Release: granted cyc_i=0 sampled -> state=IDLE, grant_o=0 next cycle. One mandatory dead cycle follows before the next grant, including when another master is waiting.
- ack: wbN_ack_o = wbowner_ack_i & grant_o[N] & state==GRANT.
  - ack in the same cycle the master drops cyc is legal; release proceeds normally.
- Watchdog:
  - Counts cycles with owner stb=1 and ack=0.
  - Clears on ack, on stb=0, or on leaving GRANT.
  - Saturating; never wraps.
  - When count==TIMEOUT-1 and no ack this cycle: timeout_fire=1 for one cycle. Effects that cycle: granted err_o=1, wbowner_stb_o forced 0, counter reset to 0. The grant is kept.
  - ack and timeout in the same cycle: ack wins, no err.
- Master holding cyc_i with stb_i=0 keeps the bus indefinitely; the watchdog does not count.
- Reset asserted mid-transfer: at that edge everything returns to reset values. Owner cyc/stb drop with no ack/err issued.
- Owner inputs that change while ungranted have no effect on wbowner_* outputs.

Test Plan:
- Reset, then masters 1 and 3 raise cyc/stb together: grant_o=0001 next cycle. Master 1 gets ack on its 1 read (wbowner_dat_i=32'h12345678 seen on wb1_dat_o) and drops cyc. One idle cycle (grant_o=0), then grant_o=0100.
- All four request continuously, each doing one single-beat transfer: grant order 1,2,3,4,1 with exactly one grant_o=0 cycle between each.
- Master 2 issues 3 strobes under one cyc while master 4 requests: wbowner_adr_o shows only master-2 addresses (e.g. 0x100, 0x104, 0x108) until wb2_cyc_i falls. Then master 4 is granted.
- TIMEOUT=4, slave never acks, master 1 strobing: wb1_err_o pulses on the 4th stb cycle, wbowner_stb_o=0 that cycle, counter restarts. A second err pulse follows 4 cycles later; no ack ever seen.
- TIMEOUT=4, ack arrives on exactly the 4th stb cycle: wb1_ack_o=1, wb1_err_o=0.
- Reset asserted while master 3 is granted with stb high: next cycle grant_o=0, wbowner_cyc_o=0, all ack/err=0. After release of reset, master 1 wins a simultaneous 1/3 request.

Source files
------------

// File: rtl/wb_rr_arbiter4_if.sv
// Bus bundle for wb_rr_arbiter4: four Wishbone master ports, the single
// slave-side (owner) port and the one-hot grant vector.
//   slave  modport : arbiter view (masters drive *_i, arbiter drives *_o)
//   master modport : environment view (masters plus the downstream slave)
interface wb_rr_arbiter4_if;
  logic        wb1_cyc_i, wb1_stb_i, wb1_we_i;
  logic [3:0]  wb1_sel_i;
  logic [31:0] wb1_adr_i, wb1_dat_i, wb1_dat_o;
  logic        wb1_ack_o, wb1_err_o;

  logic        wb2_cyc_i, wb2_stb_i, wb2_we_i;
  logic [3:0]  wb2_sel_i;
  logic [31:0] wb2_adr_i, wb2_dat_i, wb2_dat_o;
  logic        wb2_ack_o, wb2_err_o;

  logic        wb3_cyc_i, wb3_stb_i, wb3_we_i;
  logic [3:0]  wb3_sel_i;
  logic [31:0] wb3_adr_i, wb3_dat_i, wb3_dat_o;
  logic        wb3_ack_o, wb3_err_o;

  logic        wb4_cyc_i, wb4_stb_i, wb4_we_i;
  logic [3:0]  wb4_sel_i;
  logic [31:0] wb4_adr_i, wb4_dat_i, wb4_dat_o;
  logic        wb4_ack_o, wb4_err_o;

  logic        wbowner_cyc_o, wbowner_stb_o, wbowner_we_o;
  logic [3:0]  wbowner_sel_o;
  logic [31:0] wbowner_adr_o, wbowner_dat_o, wbowner_dat_i;
  logic        wbowner_ack_i;
  logic [3:0]  grant_o;

  modport slave (
    input  wb1_cyc_i, wb1_stb_i, wb1_we_i, wb1_sel_i, wb1_adr_i, wb1_dat_i,
    output wb1_dat_o, wb1_ack_o, wb1_err_o,
    input  wb2_cyc_i, wb2_stb_i, wb2_we_i, wb2_sel_i, wb2_adr_i, wb2_dat_i,
    output wb2_dat_o, wb2_ack_o, wb2_err_o,
    input  wb3_cyc_i, wb3_stb_i, wb3_we_i, wb3_sel_i, wb3_adr_i, wb3_dat_i,
    output wb3_dat_o, wb3_ack_o, wb3_err_o,
    input  wb4_cyc_i, wb4_stb_i, wb4_we_i, wb4_sel_i, wb4_adr_i, wb4_dat_i,
    output wb4_dat_o, wb4_ack_o, wb4_err_o,
    output wbowner_cyc_o, wbowner_stb_o, wbowner_we_o, wbowner_sel_o,
    output wbowner_adr_o, wbowner_dat_o,
    input  wbowner_dat_i, wbowner_ack_i,
    output grant_o
  );

  modport master (
    output wb1_cyc_i, wb1_stb_i, wb1_we_i, wb1_sel_i, wb1_adr_i, wb1_dat_i,
    input  wb1_dat_o, wb1_ack_o, wb1_err_o,
    output wb2_cyc_i, wb2_stb_i, wb2_we_i, wb2_sel_i, wb2_adr_i, wb2_dat_i,
    input  wb2_dat_o, wb2_ack_o, wb2_err_o,
    output wb3_cyc_i, wb3_stb_i, wb3_we_i, wb3_sel_i, wb3_adr_i, wb3_dat_i,
    input  wb3_dat_o, wb3_ack_o, wb3_err_o,
    output wb4_cyc_i, wb4_stb_i, wb4_we_i, wb4_sel_i, wb4_adr_i, wb4_dat_i,
    input  wb4_dat_o, wb4_ack_o, wb4_err_o,
    input  wbowner_cyc_o, wbowner_stb_o, wbowner_we_o, wbowner_sel_o,
    input  wbowner_adr_o, wbowner_dat_o,
    output wbowner_dat_i, wbowner_ack_i,
    input  grant_o
  );
endinterface

// File: rtl/wb_rr_arbiter4.sv
// Four-master / one-slave Wishbone arbiter with round-robin fairness.
// The granted master keeps the bus for its whole cyc assertion; a slave
// that stalls with stb high is broken out with a one-cycle err pulse.
// Ports:
//   wb_clk_i : clock
//   wb_rst_i : synchronous active-high reset
//   bus      : wb_rr_arbiter4_if.slave (master ports 1..4, owner port, grant_o)
module wb_rr_arbiter4 #(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_rr_arbiter4_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_nx;
  logic [3:0]           grant, grant_nx;
  logic [1:0]           last, last_nx;
  logic [TIMEOUT_W-1:0] wdog, wdog_nx;

  logic [3:0]  cyc, stb, we;
  logic [3:0]  sel [4];
  logic [31:0] adr [4];
  logic [31:0] dat [4];

  logic        own_cyc, own_stb, own_we, fire, found;
  logic [3:0]  own_sel;
  logic [31:0] own_adr, own_dat;
  logic [1:0]  idx;

  // Index 0 corresponds to master 1 throughout.
  assign cyc = {bus.wb4_cyc_i, bus.wb3_cyc_i, bus.wb2_cyc_i, bus.wb1_cyc_i};
  assign stb = {bus.wb4_stb_i, bus.wb3_stb_i, bus.wb2_stb_i, bus.wb1_stb_i};
  assign we  = {bus.wb4_we_i,  bus.wb3_we_i,  bus.wb2_we_i,  bus.wb1_we_i};
  assign sel[0] = bus.wb1_sel_i;
  assign sel[1] = bus.wb2_sel_i;
  assign sel[2] = bus.wb3_sel_i;
  assign sel[3] = bus.wb4_sel_i;
  assign adr[0] = bus.wb1_adr_i;
  assign adr[1] = bus.wb2_adr_i;
  assign adr[2] = bus.wb3_adr_i;
  assign adr[3] = bus.wb4_adr_i;
  assign dat[0] = bus.wb1_dat_i;
  assign dat[1] = bus.wb2_dat_i;
  assign dat[2] = bus.wb3_dat_i;
  assign dat[3] = bus.wb4_dat_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= '0;
      last  <= 2'd3;
      wdog  <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      last  <= last_nx;
      wdog  <= wdog_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx  = last;
    wdog_nx  = '0;
    found    = 1'b0;
    idx      = '0;
    case (state)
      IDLE: begin
        if (|cyc) begin
          state_nx = GRANT;
          // Scan upward from the slot after the last owner, wrapping 4->1.
          for (int unsigned i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && cyc[idx]) begin
              found         = 1'b1;
              grant_nx      = '0;
              grant_nx[idx] = 1'b1;
              last_nx       = idx;
            end
          end
        end
      end
      GRANT: begin
        if (!own_cyc) begin
          state_nx = IDLE;
          grant_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
    // Counter clears on ack, stb low, firing, or leaving GRANT; saturates.
    if (state == GRANT && own_cyc && own_stb && !bus.wbowner_ack_i &&
        !fire && wdog != '1)
      wdog_nx = wdog + 1'b1;
  end

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (state == GRANT && grant[i]) begin
        own_cyc = cyc[i];
        own_stb = stb[i];
        own_we  = we[i];
        own_sel = sel[i];
        own_adr = adr[i];
        own_dat = dat[i];
      end
    end
    fire = (state == GRANT) && own_stb && !bus.wbowner_ack_i &&
           (wdog == TIMEOUT_W'(TIMEOUT - 1));
  end

  assign bus.wbowner_cyc_o = own_cyc;
  assign bus.wbowner_stb_o = own_stb & ~fire;
  assign bus.wbowner_we_o  = own_we;
  assign bus.wbowner_sel_o = own_sel;
  assign bus.wbowner_adr_o = own_adr;
  assign bus.wbowner_dat_o = own_dat;
  assign bus.grant_o       = grant;

  logic [3:0] ack_v, err_v;
  assign ack_v = {4{bus.wbowner_ack_i && state == GRANT}} & grant;
  assign err_v = {4{fire}} & grant;

  assign bus.wb1_ack_o = ack_v[0];
  assign bus.wb2_ack_o = ack_v[1];
  assign bus.wb3_ack_o = ack_v[2];
  assign bus.wb4_ack_o = ack_v[3];
  assign bus.wb1_err_o = err_v[0];
  assign bus.wb2_err_o = err_v[1];
  assign bus.wb3_err_o = err_v[2];
  assign bus.wb4_err_o = err_v[3];
  assign bus.wb1_dat_o = bus.wbowner_dat_i;
  assign bus.wb2_dat_o = bus.wbowner_dat_i;
  assign bus.wb3_dat_o = bus.wbowner_dat_i;
  assign bus.wb4_dat_o = bus.wbowner_dat_i;

endmodule

// File: tb/tb_wb_rr_arbiter4.sv
// Self-checking bench for wb_rr_arbiter4 (built with TIMEOUT=4).
module tb_wb_rr_arbiter4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_rr_arbiter4_if bus ();

  wb_rr_arbiter4 #(.TIMEOUT_W(8), .TIMEOUT(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] cyc;
    logic [3:0] stb;
    logic       ack;
    logic [3:0] gnt;
    logic       ocyc;
    logic       ostb;
    logic [3:0] acko;
    logic [3:0] erro;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  task automatic addv(input logic r, input logic [3:0] c, input logic [3:0] s,
                      input logic a, input logic [3:0] g, input logic oc,
                      input logic os, input logic [3:0] ao, input logic [3:0] eo);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.ack = a; v.gnt = g;
    v.ocyc = oc; v.ostb = os; v.acko = ao; v.erro = eo;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] s, input logic a);
    bus.wb1_cyc_i = c[0]; bus.wb2_cyc_i = c[1]; bus.wb3_cyc_i = c[2]; bus.wb4_cyc_i = c[3];
    bus.wb1_stb_i = s[0]; bus.wb2_stb_i = s[1]; bus.wb3_stb_i = s[2]; bus.wb4_stb_i = s[3];
    bus.wbowner_ack_i = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] acks();
    return {bus.wb4_ack_o, bus.wb3_ack_o, bus.wb2_ack_o, bus.wb1_ack_o};
  endfunction

  function automatic logic [3:0] errs();
    return {bus.wb4_err_o, bus.wb3_err_o, bus.wb2_err_o, bus.wb1_err_o};
  endfunction

  function automatic logic [31:0] exp_adr(input logic [3:0] g);
    logic [31:0] a;
    a = '0;
    for (int i = 0; i < 4; i++)
      if (g[i]) a = 32'h1000 * (i + 1);
    return a;
  endfunction

  initial begin
    vec_t v;
    logic [3:0] oh;
    logic f;

    drive(4'h0, 4'h0, 1'b0);
    bus.wbowner_dat_i = 32'h12345678;
    bus.wb1_we_i = 1'b0; bus.wb2_we_i = 1'b1; bus.wb3_we_i = 1'b0; bus.wb4_we_i = 1'b1;
    bus.wb1_sel_i = 4'h1; bus.wb2_sel_i = 4'h3; bus.wb3_sel_i = 4'h7; bus.wb4_sel_i = 4'hF;
    bus.wb1_adr_i = 32'h1000; bus.wb2_adr_i = 32'h2000;
    bus.wb3_adr_i = 32'h3000; bus.wb4_adr_i = 32'h4000;
    bus.wb1_dat_i = 32'hD1; bus.wb2_dat_i = 32'hD2; bus.wb3_dat_i = 32'hD3; bus.wb4_dat_i = 32'hD4;

    // Masters 1 and 3 request together after reset.
    addv(0, 4'b0101, 4'b0101, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addv(0, 4'b0101, 4'b0101, 1, 4'b0001, 1, 1, 4'b0001, 4'b0000);
    addv(0, 4'b0100, 4'b0100, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000);
    addv(0, 4'b0100, 4'b0100, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addv(0, 4'b0100, 4'b0100, 1, 4'b0100, 1, 1, 4'b0100, 4'b0000);
    addv(0, 4'b0000, 4'b0000, 0, 4'b0100, 0, 0, 4'b0000, 4'b0000);
    addv(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);

    // All four requesting continuously: grant order 1,2,3,4,1.
    addv(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      addv(0, 4'hF, 4'hF, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
      addv(0, 4'hF, 4'hF, 1, oh, 1, 1, oh, 4'b0000);
      addv(0, 4'hF & ~oh, 4'hF & ~oh, 0, oh, 0, 0, 4'b0000, 4'b0000);
    end
    addv(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);

    // Slave never acks: err on every 4th strobe cycle, stb suppressed then.
    addv(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addv(0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    for (int s = 1; s <= 8; s++) begin
      f = (s % 4 == 0);
      addv(0, 4'b0001, 4'b0001, 0, 4'b0001, 1, !f, 4'b0000, {3'b000, f});
    end
    addv(0, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000);
    addv(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);

    // Ack on exactly the 4th strobe cycle beats the watchdog.
    addv(0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    for (int s = 1; s <= 3; s++)
      addv(0, 4'b0001, 4'b0001, 0, 4'b0001, 1, 1, 4'b0000, 4'b0000);
    addv(0, 4'b0001, 4'b0001, 1, 4'b0001, 1, 1, 4'b0001, 4'b0000);
    addv(0, 4'b0001, 4'b0001, 0, 4'b0001, 1, 1, 4'b0000, 4'b0000);
    addv(0, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000);
    addv(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);

    // Initial reset and reset-state checks.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_grant", {28'h0, bus.grant_o}, 32'h0);
    chk("reset_ocyc", {31'h0, bus.wbowner_cyc_o}, 32'h0);
    chk("reset_ostb", {31'h0, bus.wbowner_stb_o}, 32'h0);
    chk("reset_acks", {28'h0, acks()}, 32'h0);
    chk("reset_errs", {28'h0, errs()}, 32'h0);
    step();

    foreach (tbl[i]) begin
      v = tbl[i];
      rst = v.rst;
      drive(v.cyc, v.stb, v.ack);
      @(negedge clk);
      chk($sformatf("v%0d_grant", i), {28'h0, bus.grant_o}, {28'h0, v.gnt});
      chk($sformatf("v%0d_ocyc", i), {31'h0, bus.wbowner_cyc_o}, {31'h0, v.ocyc});
      chk($sformatf("v%0d_ostb", i), {31'h0, bus.wbowner_stb_o}, {31'h0, v.ostb});
      chk($sformatf("v%0d_acko", i), {28'h0, acks()}, {28'h0, v.acko});
      chk($sformatf("v%0d_erro", i), {28'h0, errs()}, {28'h0, v.erro});
      if (v.ocyc)
        chk($sformatf("v%0d_oadr", i), bus.wbowner_adr_o, exp_adr(v.gnt));
      if (v.acko[0])
        chk($sformatf("v%0d_rdat1", i), bus.wb1_dat_o, 32'h12345678);
      step();
    end
    rst = 1'b0;

    // Master 2 locks the bus for three strobes while master 4 waits.
    rst = 1'b1; drive(4'h0, 4'h0, 1'b0); step(); rst = 1'b0;
    bus.wb2_adr_i = 32'h100;
    drive(4'b1010, 4'b1000, 1'b0);
    @(negedge clk);
    chk("lock_idle_grant", {28'h0, bus.grant_o}, 32'h0);
    step();
    for (int b = 0; b < 3; b++) begin
      bus.wb2_adr_i = 32'h100 + 32'(4 * b);
      bus.wb4_adr_i = 32'h4000 + 32'(b);
      drive(4'b1010, 4'b1010, 1'b1);
      @(negedge clk);
      chk($sformatf("lock%0d_grant", b), {28'h0, bus.grant_o}, 32'h2);
      chk($sformatf("lock%0d_adr", b), bus.wbowner_adr_o, 32'h100 + 32'(4 * b));
      chk($sformatf("lock%0d_acks", b), {28'h0, acks()}, 32'h2);
      step();
      drive(4'b1010, 4'b1000, 1'b0);
      @(negedge clk);
      chk($sformatf("lock%0d_gap_stb", b), {31'h0, bus.wbowner_stb_o}, 32'h0);
      chk($sformatf("lock%0d_gap_grant", b), {28'h0, bus.grant_o}, 32'h2);
      step();
    end
    bus.wb4_adr_i = 32'h4000;
    drive(4'b1000, 4'b1000, 1'b0);
    @(negedge clk);
    chk("lock_rel_grant", {28'h0, bus.grant_o}, 32'h2);
    chk("lock_rel_ocyc", {31'h0, bus.wbowner_cyc_o}, 32'h0);
    step();
    @(negedge clk);
    chk("lock_dead_grant", {28'h0, bus.grant_o}, 32'h0);
    step();
    drive(4'b1000, 4'b1000, 1'b1);
    @(negedge clk);
    chk("lock_m4_grant", {28'h0, bus.grant_o}, 32'h8);
    chk("lock_m4_adr", bus.wbowner_adr_o, 32'h4000);
    chk("lock_m4_acks", {28'h0, acks()}, 32'h8);
    step();
    drive(4'h0, 4'h0, 1'b0);
    bus.wb2_adr_i = 32'h2000;
    step();
    step();

    // Reset while master 3 owns the bus with stb high.
    drive(4'b0100, 4'b0100, 1'b0);
    @(negedge clk);
    chk("rstx_idle_grant", {28'h0, bus.grant_o}, 32'h0);
    step();
    @(negedge clk);
    chk("rstx_m3_grant", {28'h0, bus.grant_o}, 32'h4);
    chk("rstx_m3_ostb", {31'h0, bus.wbowner_stb_o}, 32'h1);
    rst = 1'b1;
    drive(4'b0100, 4'b0100, 1'b1);
    step();
    @(negedge clk);
    chk("rstx_grant", {28'h0, bus.grant_o}, 32'h0);
    chk("rstx_ocyc", {31'h0, bus.wbowner_cyc_o}, 32'h0);
    chk("rstx_ostb", {31'h0, bus.wbowner_stb_o}, 32'h0);
    chk("rstx_acks", {28'h0, acks()}, 32'h0);
    chk("rstx_errs", {28'h0, errs()}, 32'h0);
    rst = 1'b0;
    drive(4'b0101, 4'b0101, 1'b0);
    step();
    @(negedge clk);
    chk("rstx_after_grant", {28'h0, bus.grant_o}, 32'h1);
    chk("rstx_after_adr", bus.wbowner_adr_o, 32'h1000);
    step();
    drive(4'h0, 4'h0, 1'b0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
